// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the generator and the sync decoder,
// plus the decoder lock-state type.
package vga_timing_pkg;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;
    localparam int unsigned V_ACTIVE = 480;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [9:0] sat_inc10(input logic [9:0] val);
        return (val == 10'h3FF) ? val : val + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_sampler.sv
// Registers HS/VS on pixel-enable cycles and flags their rising edges.
module vga_sync_sampler (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pix_en,
    input  logic i_hs,
    input  logic i_vs,
    output logic o_hs_rise,
    output logic o_vs_rise
);

    logic r_hs;
    logic r_vs;

    // Previous-sample history, advanced only when a pixel is sampled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hs <= 1'b0;
            r_vs <= 1'b0;
        end else if (i_pix_en) begin
            r_hs <= i_hs;
            r_vs <= i_vs;
        end
    end

    assign o_hs_rise = i_pix_en & i_hs & ~r_hs;
    assign o_vs_rise = i_pix_en & i_vs & ~r_vs;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position, data-enable and lock status from an HS/VS pair.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned HTotal  = H_TOTAL,
    parameter int unsigned HSync   = H_SYNC,
    parameter int unsigned HBack   = H_BACK,
    parameter int unsigned HActive = H_ACTIVE,
    parameter int unsigned VTotal  = V_TOTAL,
    parameter int unsigned VSync   = V_SYNC,
    parameter int unsigned VBack   = V_BACK,
    parameter int unsigned VActive = V_ACTIVE
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_en,
    input  logic       i_hs,
    input  logic       i_vs,
    output logic       o_de,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_locked,
    output logic       o_frame_start,
    output logic       o_sync_err,
    output logic [9:0] o_line_len
);

    localparam logic [9:0] HTot   = 10'(HTotal);
    localparam logic [9:0] HStart = 10'(HSync + HBack);
    localparam logic [9:0] HEnd   = 10'(HSync + HBack + HActive);
    localparam logic [9:0] VTot   = 10'(VTotal);
    localparam logic [9:0] VStart = 10'(VSync + VBack);
    localparam logic [9:0] VEnd   = 10'(VSync + VBack + VActive);

    logic       w_hs_rise;
    logic       w_vs_rise;
    logic       w_frame_start;
    logic [9:0] w_p_plus1;
    logic [9:0] w_l_plus1;
    logic [9:0] w_p_next;
    logic [9:0] w_l_next;
    logic       w_line_bad;
    logic       w_frame_bad;
    logic       w_timeout;
    logic       w_to_search;
    logic       w_to_locked;
    logic       w_locked_next;
    logic       w_de_next;

    logic [9:0] r_p;
    logic [9:0] r_l;
    logic       r_vs_pend;
    logic       r_seen_h;
    logic       r_line_bad_acc;
    state_t     r_state;
    logic       r_de;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_frame_start;
    logic       r_sync_err;
    logic [9:0] r_line_len;

    vga_sync_sampler u_sampler (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_pix_en  (i_pix_en),
        .i_hs      (i_hs),
        .i_vs      (i_vs),
        .o_hs_rise (w_hs_rise),
        .o_vs_rise (w_vs_rise)
    );

    // A VS rise is only accepted as a frame start when it lines up with an HS rise.
    assign w_frame_start = w_hs_rise & (w_vs_rise | r_vs_pend);
    assign w_p_plus1     = r_p + 10'd1;
    assign w_l_plus1     = r_l + 10'd1;
    assign w_p_next      = w_hs_rise ? 10'd0 : sat_inc10(r_p);
    assign w_l_next      = !w_hs_rise ? r_l : ((w_vs_rise | r_vs_pend) ? 10'd0 : sat_inc10(r_l));
    assign w_line_bad    = w_hs_rise & r_seen_h & (w_p_plus1 != HTot);
    assign w_frame_bad   = w_frame_start & (w_l_plus1 != VTot);
    // Fires once, on the sample that drives p into saturation.
    assign w_timeout     = i_pix_en & ~w_hs_rise & (r_p == 10'd1022);

    assign w_to_search = ((r_state == LOCKED) & (w_line_bad | w_frame_bad | w_timeout)) |
                         ((r_state == VERIFY) & w_timeout);
    assign w_to_locked = (r_state == VERIFY) & w_frame_start & ~w_frame_bad & ~w_line_bad &
                         ~r_line_bad_acc;

    assign w_locked_next = ((r_state == LOCKED) & ~w_to_search) | w_to_locked;
    assign w_de_next     = w_locked_next & (w_p_next >= HStart) & (w_p_next < HEnd) &
                           (w_l_next >= VStart) & (w_l_next < VEnd);

    // Position/line counters, pending-VS flag and measured line length.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p        <= 10'd0;
            r_l        <= 10'd0;
            r_vs_pend  <= 1'b0;
            r_line_len <= 10'd0;
        end else if (i_pix_en) begin
            r_p <= w_p_next;
            r_l <= w_l_next;
            if (w_hs_rise) begin
                r_vs_pend <= 1'b0;
                if (r_seen_h) begin
                    r_line_len <= w_p_plus1;
                end
            end else if (w_vs_rise) begin
                r_vs_pend <= 1'b1;
            end
        end
    end

    // Lock FSM with its registered frame_start/sync_err pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= SEARCH;
            r_seen_h       <= 1'b0;
            r_line_bad_acc <= 1'b0;
            r_frame_start  <= 1'b0;
            r_sync_err     <= 1'b0;
        end else begin
            r_frame_start <= w_frame_start;
            r_sync_err    <= 1'b0;
            if (i_pix_en) begin
                if (w_hs_rise) begin
                    r_seen_h <= 1'b1;
                end
                unique case (r_state)
                    SEARCH: begin
                        if (w_frame_start) begin
                            r_state        <= VERIFY;
                            r_line_bad_acc <= 1'b0;
                        end
                    end
                    VERIFY: begin
                        if (w_timeout) begin
                            r_state    <= SEARCH;
                            r_sync_err <= 1'b1;
                            r_seen_h   <= 1'b0;
                        end else if (w_frame_start) begin
                            r_line_bad_acc <= 1'b0;
                            if (w_to_locked) begin
                                r_state <= LOCKED;
                            end else begin
                                r_sync_err <= 1'b1;
                            end
                        end else if (w_line_bad) begin
                            r_line_bad_acc <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (w_to_search) begin
                            r_state    <= SEARCH;
                            r_sync_err <= 1'b1;
                            r_seen_h   <= 1'b0;
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    // Registered active-area decode from the post-update position and lock state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_de <= 1'b0;
            r_x  <= 10'd0;
            r_y  <= 10'd0;
        end else if (i_pix_en) begin
            r_de <= w_de_next;
            r_x  <= w_de_next ? (w_p_next - HStart) : 10'd0;
            r_y  <= w_de_next ? (w_l_next - VStart) : 10'd0;
        end
    end

    assign o_de          = r_de;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_locked      = (r_state == LOCKED);
    assign o_frame_start = r_frame_start;
    assign o_sync_err    = r_sync_err;
    assign o_line_len    = r_line_len;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced raster (50x12 total, 36x6 active)
// so that many frames fit in a short run; pix_en is high one clk in four.
module tb_vga_sync_decoder;

    localparam int unsigned HT  = 50;
    localparam int unsigned HSW = 6;
    localparam int unsigned HBP = 4;
    localparam int unsigned HAC = 36;
    localparam int unsigned VT  = 12;
    localparam int unsigned VSW = 2;
    localparam int unsigned VBP = 3;
    localparam int unsigned VAC = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
    logic [9:0] line_len;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .HTotal  (HT),
        .HSync   (HSW),
        .HBack   (HBP),
        .HActive (HAC),
        .VTotal  (VT),
        .VSync   (VSW),
        .VBack   (VBP),
        .VActive (VAC)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pix_en      (pix_en),
        .i_hs          (hs),
        .i_vs          (vs),
        .o_de          (de),
        .o_x           (x),
        .o_y           (y),
        .o_locked      (locked),
        .o_frame_start (frame_start),
        .o_sync_err    (sync_err),
        .o_line_len    (line_len)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_de, n_fs, n_err, xy_nz;
    int first_x, first_y, last_x, last_y;
    int lk_at_fs, lk_at_err, ll_at_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One enabled sample, then three idle clks; records what the decoder reports.
    task automatic pix(input logic h, input logic v);
        logic fs_seen, err_seen;
        @(negedge clk);
        hs = h;
        vs = v;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        if (de) begin
            if (n_de == 0) begin
                first_x = int'(x);
                first_y = int'(y);
            end
            last_x = int'(x);
            last_y = int'(y);
            n_de++;
        end else if (x != 10'd0 || y != 10'd0) begin
            xy_nz++;
        end
        if (frame_start) begin
            n_fs++;
            lk_at_fs = int'(locked);
        end
        if (sync_err) begin
            n_err++;
            lk_at_err = int'(locked);
            ll_at_err = int'(line_len);
        end
        fs_seen = frame_start;
        err_seen = sync_err;
        @(negedge clk);
        if (fs_seen) chk("fs_pulse_width", frame_start, 0);
        if (err_seen) chk("err_pulse_width", sync_err, 0);
        @(negedge clk);
    endtask

    // Generator pixels h0..h1-1 of line v (HS while h<HSW, VS while v<VSW).
    task automatic span(input int v, input int h0, input int h1);
        for (int h = h0; h < h1; h++) pix(h < HSW, v < VSW);
    endtask

    // Whole frame; short_line gets HT-1 samples, early_vs raises VS on the last sample.
    task automatic frame(input int nlines, input int short_line, input bit early_vs);
        for (int v = 0; v < nlines; v++) begin
            int len;
            len = (v == short_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++)
                pix(h < HSW, (v < VSW) || (early_vs && v == nlines - 1 && h == len - 1));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_sync_err"}, sync_err, 0);
        chk({tag, "_line_len"}, line_len, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        pix_en = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        n_de = 0; n_fs = 0; n_err = 0; xy_nz = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        lk_at_fs = -1; lk_at_err = -1; ll_at_err = -1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Frame 1: first VS rise, enters VERIFY.
        frame(VT, -1, 1'b0);
        chk("f1_fs_count", n_fs, 1);
        chk("f1_lock_at_fs", lk_at_fs, 0);
        chk("f1_locked", locked, 0);
        chk("f1_de_count", n_de, 0);
        chk("f1_line_len", line_len, HT);

        // Frame 2: second VS rise locks; full active area follows.
        n_de = 0;
        frame(VT, -1, 1'b0);
        chk("f2_fs_count", n_fs, 2);
        chk("f2_lock_at_fs", lk_at_fs, 1);
        chk("f2_locked", locked, 1);
        chk("f2_de_count", n_de, HAC * VAC);
        chk("f2_first_x", first_x, 0);
        chk("f2_first_y", first_y, 0);
        chk("f2_last_x", last_x, HAC - 1);
        chk("f2_last_y", last_y, VAC - 1);
        chk("f2_err_count", n_err, 0);

        n_de = 0;
        frame(VT, -1, 1'b0);
        chk("f3_de_count", n_de, HAC * VAC);
        chk("f3_locked", locked, 1);

        // Frame 4: line 7 is one sample short; lock drops at the next HS rise.
        n_de = 0;
        frame(VT, 7, 1'b0);
        chk("short_err_count", n_err, 1);
        chk("short_line_len", ll_at_err, HT - 1);
        chk("short_lock_at_err", lk_at_err, 0);
        chk("short_locked", locked, 0);
        chk("short_de_count", n_de, 3 * HAC);

        frame(VT, -1, 1'b0);
        chk("short_relock_f5", locked, 0);
        frame(VT, -1, 1'b0);
        chk("short_relock_f6", locked, 1);
        chk("short_relock_err", n_err, 1);

        // Frame 7 has VT-1 lines; caught at frame 8's VS rise.
        frame(VT - 1, -1, 1'b0);
        chk("badf_pre_locked", locked, 1);
        chk("badf_pre_err", n_err, 1);
        n_de = 0;
        frame(VT, -1, 1'b0);
        chk("badf_err_count", n_err, 2);
        chk("badf_lock_at_err", lk_at_err, 0);
        chk("badf_locked", locked, 0);
        chk("badf_de_count", n_de, 0);
        frame(VT, -1, 1'b0);
        chk("badf_relock_f9", locked, 0);
        frame(VT, -1, 1'b0);
        chk("badf_relock_f10", locked, 1);

        // HS stuck low: position saturates, one error, lock lost.
        repeat (1100) pix(1'b0, 1'b0);
        chk("stuck_err_count", n_err, 3);
        chk("stuck_lock_at_err", lk_at_err, 0);
        chk("stuck_locked", locked, 0);
        chk("stuck_de", de, 0);

        // VS rises one sample ahead of HS on each frame boundary.
        frame(VT, -1, 1'b1);
        chk("early_f11_locked", locked, 0);
        n_de = 0;
        frame(VT, -1, 1'b1);
        chk("early_locked", locked, 1);
        chk("early_err_count", n_err, 3);
        chk("early_de_count", n_de, HAC * VAC);
        chk("early_first_y", first_y, 0);
        chk("early_last_y", last_y, VAC - 1);

        // Reset mid-line while locked and inside the active area.
        for (int v = 0; v < 6; v++) span(v, 0, HT);
        span(6, 0, 20);
        chk("pre_rst_de", de, 1);
        chk("pre_rst_x", x, 9);
        chk("pre_rst_y", y, 1);
        chk("pre_rst_locked", locked, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        n_fs = 0;
        span(6, 20, HT);
        for (int v = 7; v < VT; v++) span(v, 0, HT);
        chk("rst_tail_fs", n_fs, 0);
        chk("rst_tail_locked", locked, 0);
        chk("rst_tail_err", n_err, 3);
        frame(VT, -1, 1'b0);
        chk("rst_f14_fs", n_fs, 1);
        chk("rst_f14_locked", locked, 0);
        n_de = 0;
        frame(VT, -1, 1'b0);
        chk("rst_f15_fs", n_fs, 2);
        chk("rst_f15_locked", locked, 1);
        chk("rst_f15_de_count", n_de, HAC * VAC);
        chk("rst_f15_err", n_err, 3);

        chk("xy_zero_outside_de", xy_nz, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
